// File: rtl/shuffle_memory.sv
// -----------------------------------------------------------------------------
// shuffle_memory
//   Runs the RC4 key-scheduling algorithm (KSA) over an external 256-byte
//   S-RAM that already holds S[i] = i. The key is fixed at 3 bytes. For each
//   i = 0..255 the block reads S[i], updates j, reads S[j], then writes the
//   swapped pair back. Every iteration takes exactly 9 cycles.
//
//   The RAM read port has two cycles of latency. Read data for an address
//   driven in RD_x is sampled in GET_x.
//
// Ports
//   clk          single clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        begins a pass; sampled only in IDLE or DONE
//   secret_key   K0 = [23:16], K1 = [15:8], K2 = [7:0]; held stable by the user
//   data_in      S-RAM read data
//   address_out  S-RAM address (registered)
//   data_out     S-RAM write data (registered)
//   is_write     S-RAM write enable (registered, active-high)
//   finish       pass-complete level; cleared by the next start or by reset
// -----------------------------------------------------------------------------
module shuffle_memory (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    input  logic [7:0]  data_in,
    output logic [7:0]  address_out,
    output logic [7:0]  data_out,
    output logic        is_write,
    output logic        finish
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_WAIT_I,
        S_GET_I,
        S_RD_J,
        S_WAIT_J,
        S_GET_J,
        S_WR_I,
        S_WR_J,
        S_NEXT,
        S_DONE
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_i, w_i_next;
    logic [7:0] r_j, w_j_next;
    logic [7:0] r_si, w_si_next;
    logic [7:0] r_sj, w_sj_next;
    logic [1:0] r_kidx, w_kidx_next;
    logic [7:0] r_addr, w_addr_next;
    logic [7:0] r_wdata, w_wdata_next;
    logic       r_we, w_we_next;
    logic       r_finish, w_finish_next;
    logic [7:0] w_key_byte;

    // Key byte for the current iteration. A mod-3 counter replaces i mod 3.
    always_comb begin
        case (r_kidx)
            2'd0:    w_key_byte = secret_key[23:16];
            2'd1:    w_key_byte = secret_key[15:8];
            default: w_key_byte = secret_key[7:0];
        endcase
    end

    // The RAM-facing outputs are computed together with the next state.
    // They then take their value on the same edge that enters the state they
    // belong to. For example, address_out already equals i throughout RD_I.
    always_comb begin
        // NOTE: every signal gets a default first, so that no path through the case infers a latch.
        w_state_next  = r_state;
        w_i_next      = r_i;
        w_j_next      = r_j;
        w_si_next     = r_si;
        w_sj_next     = r_sj;
        w_kidx_next   = r_kidx;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_we_next     = 1'b0;
        w_finish_next = r_finish;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next  = S_RD_I;
                    w_i_next      = 8'd0;
                    w_j_next      = 8'd0;
                    w_kidx_next   = 2'd0;
                    w_finish_next = 1'b0;
                    w_addr_next   = 8'd0;
                end
            end
            S_RD_I:   w_state_next = S_WAIT_I;
            S_WAIT_I: w_state_next = S_GET_I;
            S_GET_I: begin
                // 8-bit wrap is the mod-256 of the KSA.
                w_si_next    = data_in;
                w_j_next     = r_j + data_in + w_key_byte;
                w_addr_next  = r_j + data_in + w_key_byte;
                w_state_next = S_RD_J;
            end
            S_RD_J:   w_state_next = S_WAIT_J;
            S_WAIT_J: w_state_next = S_GET_J;
            S_GET_J: begin
                w_sj_next    = data_in;
                w_addr_next  = r_i;
                w_wdata_next = data_in;
                w_we_next    = 1'b1;
                w_state_next = S_WR_I;
            end
            S_WR_I: begin
                // When i == j the second write carries si, so S[i] is left
                // unchanged with no special case.
                w_addr_next  = r_j;
                w_wdata_next = r_si;
                w_we_next    = 1'b1;
                w_state_next = S_WR_J;
            end
            S_WR_J:   w_state_next = S_NEXT;
            S_NEXT: begin
                if (r_i == 8'd255) begin
                    w_finish_next = 1'b1;
                    w_state_next  = S_DONE;
                end else begin
                    w_i_next     = r_i + 8'd1;
                    w_kidx_next  = (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
                    w_addr_next  = r_i + 8'd1;
                    w_state_next = S_RD_I;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_i      <= 8'd0;
            r_j      <= 8'd0;
            r_si     <= 8'd0;
            r_sj     <= 8'd0;
            r_kidx   <= 2'd0;
            r_addr   <= 8'd0;
            r_wdata  <= 8'd0;
            r_we     <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_i      <= w_i_next;
            r_j      <= w_j_next;
            r_si     <= w_si_next;
            r_sj     <= w_sj_next;
            r_kidx   <= w_kidx_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_we     <= w_we_next;
            r_finish <= w_finish_next;
        end
    end

    assign address_out = r_addr;
    assign data_out    = r_wdata;
    assign is_write    = r_we;
    assign finish      = r_finish;

endmodule

// File: tb/tb_shuffle_memory.sv
// -----------------------------------------------------------------------------
// tb_shuffle_memory
//   Directed bench for shuffle_memory. It includes an S-RAM model with two
//   cycles of read latency, a write monitor that counts writes and logs the
//   first eight, and a software KSA that produces the final RAM image.
// -----------------------------------------------------------------------------
module tb_shuffle_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  data_in;
    logic [7:0]  address_out;
    logic [7:0]  data_out;
    logic        is_write;
    logic        finish;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem  [256];
    logic [7:0] gold [256];
    logic [7:0] q1, q2;
    logic       fill_identity = 1'b0;
    logic       clr_mon = 1'b0;
    int         wr_count;
    logic [7:0] log_addr [8];
    logic [7:0] log_data [8];

    shuffle_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .secret_key  (secret_key),
        .data_in     (data_in),
        .address_out (address_out),
        .data_out    (data_out),
        .is_write    (is_write),
        .finish      (finish)
    );

    always #5 clk = ~clk;

    assign data_in = q2;

    // S-RAM model: a synchronous read with an extra output register gives
    // data two edges after the address. The write monitor is also here.
    always @(posedge clk) begin
        q1 <= mem[address_out];
        q2 <= q1;
        if (fill_identity) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (is_write) begin
            mem[address_out] <= data_out;
        end
        if (clr_mon) begin
            wr_count <= 0;
        end else if (is_write) begin
            if (wr_count < 8) begin
                log_addr[wr_count[2:0]] <= address_out;
                log_data[wr_count[2:0]] <= data_out;
            end
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram();
        fill_identity = 1'b1;
        clr_mon       = 1'b1;
        tick();
        fill_identity = 1'b0;
        clr_mon       = 1'b0;
    endtask

    task automatic compute_golden(input logic [23:0] key);
        int jj;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int k = 0; k < 256; k++) gold[k] = 8'(k);
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + int'(gold[ii]) + int'(kb[ii % 3])) % 256;
            t        = gold[ii];
            gold[ii] = gold[jj];
            gold[jj] = t;
        end
    endtask

    // Pulses start for one cycle. Returns 1 ns after the sampling edge.
    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until finish is seen.
    // Optionally pulses start again at cycle inject_at.
    task automatic wait_finish(input int inject_at, output int cycles);
        cycles = 0;
        while (!finish && cycles < 3000) begin
            start = (cycles == inject_at);
            tick();
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic check_pass(input string name, input int cycles);
        int mism;
        checks++;
        if (cycles !== 2304) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected 2304", name, cycles);
        end
        checks++;
        if (wr_count !== 512) begin
            errors++;
            $display("FAIL %s_write_count: got %0d, expected 512", name, wr_count);
        end
        mism = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) mism++;
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL %s_ram_golden: %0d bytes differ, expected 0", name, mism);
        end
    endtask

    task automatic check_first_writes(input string name, input logic [7:0] ea [6],
                                      input logic [7:0] ed [6]);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_addr[k] !== ea[k] || log_data[k] !== ed[k]) begin
                errors++;
                $display("FAIL %s_write%0d: got addr %h data %h, expected addr %h data %h",
                         name, k, log_addr[k], log_data[k], ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        secret_key = 24'h0;
        fill_ram();
        tick();
        checks++;
        if ({address_out, data_out, is_write, finish} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got addr %h data %h we %b fin %b, expected all 0",
                     address_out, data_out, is_write, finish);
        end
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (wr_count !== 0 || address_out !== 8'h0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got writes %0d addr %h fin %b, expected 0/00/0",
                     wr_count, address_out, finish);
        end
    endtask

    task automatic test_zero_key();
        int cyc;
        logic [7:0] ea [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
        logic [7:0] ed [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
        secret_key = 24'h000000;
        compute_golden(secret_key);
        fill_ram();
        start_pass();
        checks++;
        if (address_out !== 8'h00 || is_write !== 1'b0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL zero_rd_i0: got addr %h we %b fin %b, expected 00/0/0",
                     address_out, is_write, finish);
        end
        wait_finish(-1, cyc);
        check_first_writes("zero", ea, ed);
        check_pass("zero", cyc);
        repeat (5) tick();
        checks++;
        if (finish !== 1'b1 || is_write !== 1'b0) begin
            errors++;
            $display("FAIL zero_finish_held: got fin %b we %b, expected 1/0", finish, is_write);
        end
    endtask

    task automatic test_key_033c();
        int cyc;
        // K = 00,03,3C: i=1 -> j=4, i=2 -> j=4+2+0x3C=0x42
        logic [7:0] ea [6] = '{8'h00, 8'h00, 8'h01, 8'h04, 8'h02, 8'h42};
        logic [7:0] ed [6] = '{8'h00, 8'h00, 8'h04, 8'h01, 8'h42, 8'h02};
        secret_key = 24'h00033C;
        compute_golden(secret_key);
        fill_ram();
        start_pass();
        wait_finish(-1, cyc);
        check_first_writes("k033c", ea, ed);
        check_pass("k033c", cyc);
    endtask

    task automatic test_ignore_start();
        int cyc;
        fill_ram();
        start_pass();
        wait_finish(99, cyc);
        check_pass("ignore_start", cyc);
    endtask

    task automatic test_restart_from_done();
        int cyc;
        fill_ram();
        start_pass();
        checks++;
        if (finish !== 1'b0 || address_out !== 8'h00 || is_write !== 1'b0) begin
            errors++;
            $display("FAIL restart_rd_i0: got fin %b addr %h we %b, expected 0/00/0",
                     finish, address_out, is_write);
        end
        wait_finish(-1, cyc);
        check_pass("restart", cyc);
    endtask

    task automatic test_mid_reset();
        int cyc;
        fill_ram();
        start_pass();
        repeat (499) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({address_out, data_out, is_write, finish} !== 18'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got addr %h data %h we %b fin %b, expected all 0",
                     address_out, data_out, is_write, finish);
        end
        tick();
        rst_n   = 1'b1;
        clr_mon = 1'b1;
        tick();
        clr_mon = 1'b0;
        repeat (20) tick();
        checks++;
        if (wr_count !== 0 || address_out !== 8'h0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got writes %0d addr %h fin %b, expected 0/00/0",
                     wr_count, address_out, finish);
        end
        fill_ram();
        start_pass();
        wait_finish(-1, cyc);
        check_pass("midreset", cyc);
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_key_033c();
        test_ignore_start();
        test_restart_from_done();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shuffle_memory.md
SHUFFLE_MEMORY -- requirements
Module: shuffle_memory

Interface
REQ-001 Parameters: none; key length fixed at 3 bytes.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  begin key-scheduling pass; sampled only in IDLE or DONE.
REQ-005 secret_key  input  24  key bytes; K0=[23:16], K1=[15:8], K2=[7:0]; held stable by user during a pass.
REQ-006 data_in  input  8  S-RAM read data (q).
REQ-007 address_out  output  8  S-RAM address, registered.
REQ-008 data_out  output  8  S-RAM write data, registered.
REQ-009 is_write  output  1  S-RAM write enable, registered, active-high.
REQ-010 finish  output  1  pass complete; level, held until next start or reset.

Function
REQ-011 The block SHALL run the RC4 KSA on an S-RAM already holding S[i]=i: j=0; for i=0..255: j=(j+S[i]+K[i mod 3]) mod 256; swap S[i],S[j].
REQ-012 The RAM read model SHALL be: data_in is valid for the address presented two rising edges earlier; the block samples data_in exactly two cycles after driving a read address.
REQ-013 The FSM SHALL have states IDLE, RD_I, WAIT_I, GET_I, RD_J, WAIT_J, GET_J, WR_I, WR_J, NEXT, DONE, one cycle each except IDLE/DONE.
REQ-014 IDLE/DONE + start=1 -> RD_I; i=0, j=0, key index=0, finish=0.
REQ-015 RD_I: address_out=i, is_write=0; -> WAIT_I -> GET_I.
REQ-016 GET_I: latch si=data_in; j<=j+data_in+K[key index], 8-bit wrap, carries discarded; -> RD_J.
REQ-017 RD_J: address_out=j (updated), is_write=0; -> WAIT_J -> GET_J: latch sj=data_in; -> WR_I.
REQ-018 WR_I: address_out=i, data_out=sj, is_write=1; -> WR_J: address_out=j, data_out=si, is_write=1; -> NEXT.
REQ-019 NEXT: is_write=0; if i==255 -> DONE with finish=1, else i<=i+1, key index<=(key index+1) mod 3 (counter, no divider), -> RD_I.
REQ-020 Each iteration SHALL take exactly 9 cycles; a full pass 2304 cycles from start-sampling edge to DONE entry.
REQ-021 is_write SHALL be high only in WR_I and WR_J; exactly 512 write cycles per pass.
REQ-022 i==j: both writes target the same address, the second writes si, so S[i] is unchanged; no special case.
REQ-023 start while in any state other than IDLE/DONE SHALL be ignored.
REQ-024 start in DONE SHALL restart a pass (REQ-014); finish drops on that edge.
REQ-025 i wrap: i never increments past 255; no 257th iteration.

Reset
REQ-026 rst_n=0 at any time, including mid-pass, SHALL immediately force IDLE, i=0, j=0, key index=0, address_out=0, data_out=0, is_write=0, finish=0.
REQ-027 After reset release the block SHALL stay in IDLE with no RAM activity until start; a partial pass is not resumed.

Verification
REQ-028 Key 24'h000000, RAM filled identity, start pulse -> iteration i=2 writes addr 2 data 3 then addr 3 data 2; finish rises exactly 2304 cycles after start sample.
REQ-029 Key 24'h000000 iteration i=0 (j=0) -> two writes addr 0 data 0; RAM[0] stays 0 (i==j case).
REQ-030 Key 24'h00033C, full pass -> final RAM matches a golden software KSA for all 256 bytes; write count 512.
REQ-031 start pulsed again at cycle 100 of a pass -> ignored; finish still at cycle 2304; RAM matches golden.
REQ-032 rst_n low at cycle 500 -> outputs zero, is_write=0 on that edge; new start runs full 2304-cycle pass from i=0.
REQ-033 start pulse in DONE -> finish low next cycle, address_out=0 read in RD_I, new pass completes in 2304 cycles.
